scan_decrypt_ctrl: RTL and testbench

- Sequencer for the 128-bit scan decryption path: serial-in shifter → decrypt core → parallel-in/serial-out shifter.
- Frames one 128-bit ciphertext block at a time.
- Gates shift-in, issues key-expansion reset and start to the core, waits for core completion under a timeout, then loads the PISO and meters shift-out.
- Sits between the test-access scan port logic and the decrypt datapath.

---
 rtl/scan_decrypt_ctrl.sv | 163 ++++++++++++++++
 tb/tb_scan_decrypt_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decrypt_ctrl.sv
// scan_decrypt_ctrl: frames one ciphertext block through the scan decryption path.
// Shift-in gating, key-expansion reset, core start/wait with timeout, then PISO
// load and metered shift-out.
module scan_decrypt_ctrl #(
    parameter int BLOCK_W      = 128,
    parameter int CNT_W        = 8,
    parameter int KA_RST_CYC   = 2,
    parameter int CORE_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_go,
    input  logic             scan_in_valid,
    input  logic             scan_out_ready,
    input  logic             core_done,
    output logic             sipo_shift_en,
    output logic             core_rst_ka,
    output logic             core_start,
    output logic             core_en,
    output logic             piso_load,
    output logic             piso_shift_en,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] bit_cnt
);

    // One shared cycle timer serves both the key-reset hold and the core timeout.
    localparam int TMR_MAX = (CORE_TIMEOUT > KA_RST_CYC) ? CORE_TIMEOUT : KA_RST_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BLOCK_W - 1);
    localparam logic [TMR_W-1:0] KA_LAST  = TMR_W'(KA_RST_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(CORE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        KEY_RST,
        START,
        WAIT_CORE,
        LOAD,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic              err_nxt;

    // Next-state, counter updates and the two combinational shift strobes.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        tmr_nxt       = tmr;
        err_nxt       = err_timeout;
        sipo_shift_en = 1'b0;
        piso_shift_en = 1'b0;
        case (state)
            IDLE: begin
                if (scan_go) begin
                    state_nxt   = SHIFT_IN;
                    bit_cnt_nxt = '0;
                    err_nxt     = 1'b0;
                end
            end
            SHIFT_IN: begin
                if (scan_in_valid) begin
                    sipo_shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt   = KEY_RST;
                        bit_cnt_nxt = '0;
                        tmr_nxt     = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            KEY_RST: begin
                if (tmr == KA_LAST) begin
                    state_nxt = START;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            START: begin
                state_nxt = WAIT_CORE;
                tmr_nxt   = '0;
            end
            WAIT_CORE: begin
                if (core_done) begin
                    state_nxt = LOAD;
                end else if (tmr == TMO_LAST) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            LOAD: begin
                state_nxt   = SHIFT_OUT;
                bit_cnt_nxt = '0;
            end
            SHIFT_OUT: begin
                if (scan_out_ready) begin
                    piso_shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt   = DONE;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus the bit and cycle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmr     <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            tmr     <= tmr_nxt;
        end
    end

    // Registered control outputs, decoded from the state being entered so they are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rst_ka <= 1'b0;
            core_start  <= 1'b0;
            core_en     <= 1'b0;
            piso_load   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            core_rst_ka <= (state_nxt == KEY_RST);
            core_start  <= (state_nxt == START);
            core_en     <= (state_nxt == START) || (state_nxt == WAIT_CORE);
            piso_load   <= (state_nxt == LOAD);
            busy        <= (state_nxt != IDLE);
            frame_done  <= (state_nxt == DONE);
            err_timeout <= err_nxt;
        end
    end

endmodule

// File: tb/tb_scan_decrypt_ctrl.sv
// tb_scan_decrypt_ctrl: directed frames with a scoreboard of per-frame expectations
// (strobe counts, latency, timeout flag) popped by an independent monitor.
module tb_scan_decrypt_ctrl;

    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 8;

    logic             clk;
    logic             reset;
    logic             scan_go;
    logic             scan_in_valid;
    logic             scan_out_ready;
    logic             core_done;
    logic             sipo_shift_en;
    logic             core_rst_ka;
    logic             core_start;
    logic             core_en;
    logic             piso_load;
    logic             piso_shift_en;
    logic             busy;
    logic             frame_done;
    logic             err_timeout;
    logic [CNT_W-1:0] bit_cnt;

    typedef struct {
        int sipo;
        int ka;
        int starts;
        int loads;
        int piso;
        int lat;
        int tmo;
    } exp_t;

    exp_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int frames_done = 0;
    int excl_viol = 0;
    bit check_err_clear = 1'b0;

    scan_decrypt_ctrl #(
        .BLOCK_W(BLOCK_W),
        .CNT_W(CNT_W),
        .KA_RST_CYC(2),
        .CORE_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_go(scan_go),
        .scan_in_valid(scan_in_valid),
        .scan_out_ready(scan_out_ready),
        .core_done(core_done),
        .sipo_shift_en(sipo_shift_en),
        .core_rst_ka(core_rst_ka),
        .core_start(core_start),
        .core_en(core_en),
        .piso_load(piso_load),
        .piso_shift_en(piso_shift_en),
        .busy(busy),
        .frame_done(frame_done),
        .err_timeout(err_timeout),
        .bit_cnt(bit_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic push_exp(input int sipo, input int ka, input int starts, input int loads,
                            input int piso, input int lat, input int tmo);
        exp_t e;
        e.sipo = sipo; e.ka = ka; e.starts = starts; e.loads = loads;
        e.piso = piso; e.lat = lat; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // Monitor state.
    int  cyc = 0;
    int  go_cyc = 0;
    bit  active = 1'b0;
    bit  busy_q = 1'b0;
    bit  done_q = 1'b0;
    int  m_sipo, m_ka, m_starts, m_loads, m_piso;

    task automatic end_frame(input int lat, input int tmo);
        exp_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("[TB] FAIL unexpected_frame_end: got frame end at cycle %0d, expected none", cyc);
        end else begin
            e = exp_q.pop_front();
            check_output("frame_sipo_shifts", m_sipo, e.sipo);
            check_output("frame_ka_cycles", m_ka, e.ka);
            check_output("frame_core_starts", m_starts, e.starts);
            check_output("frame_piso_loads", m_loads, e.loads);
            check_output("frame_piso_shifts", m_piso, e.piso);
            check_output("frame_latency", lat, e.lat);
            check_output("frame_timeout_kind", tmo, e.tmo);
            check_output("frame_err_timeout", int'(err_timeout), e.tmo);
        end
    endtask

    // Monitor: counts strobes per frame and checks each finished frame against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            active = 1'b0;
            busy_q = 1'b0;
            done_q = 1'b0;
        end else begin
            if (int'(core_start) + int'(piso_load) + int'(sipo_shift_en) + int'(piso_shift_en) > 1)
                excl_viol++;
            if (scan_go && !busy) go_cyc = cyc;
            if (busy && !busy_q) begin
                active   = 1'b1;
                m_sipo   = 0;
                m_ka     = 0;
                m_starts = 0;
                m_loads  = 0;
                m_piso   = 0;
            end
            if (active) begin
                m_sipo   += int'(sipo_shift_en);
                m_ka     += int'(core_rst_ka);
                m_starts += int'(core_start);
                m_loads  += int'(piso_load);
                m_piso   += int'(piso_shift_en);
            end
            if (frame_done) begin
                frames_done++;
                if (active) end_frame(cyc - go_cyc + 1, 0);
            end else if (!busy && busy_q && !done_q && active) begin
                end_frame(cyc - go_cyc, 1);
            end
            if (!busy && busy_q) active = 1'b0;
            busy_q = busy;
            done_q = frame_done;
        end
    end

    // Drives one frame cycle by cycle; models the core's done response and the stall windows.
    task automatic apply_stimulus(input bit toggle_valid, input bit stall, input int core_delay,
                                  input bit extra_go, input int abort_at);
        int n;
        int core_due;
        int shifts_out;
        int stall_left;
        bit finished;
        n = 0; core_due = -1; shifts_out = 0; stall_left = 0; finished = 1'b0;
        while (!finished) begin
            @(posedge clk);
            #1;
            scan_go        = (n == 0) || (extra_go && (n == 135 || n == 200));
            scan_in_valid  = toggle_valid ? n[0] : 1'b1;
            scan_out_ready = (stall_left == 0);
            core_done      = (n == core_due);
            if (n == abort_at) begin
                check_output("pre_reset_bit_cnt", int'(bit_cnt), 70);
                reset = 1'b1;
                #1;
                check_output("mid_reset_strobes",
                             int'({sipo_shift_en, core_rst_ka, core_start, core_en, piso_load,
                                   piso_shift_en, busy, frame_done, err_timeout}), 0);
                check_output("mid_reset_bit_cnt", int'(bit_cnt), 0);
                finished = 1'b1;
            end
            @(negedge clk);
            if (!finished) begin
                if (core_start && core_delay >= 0) core_due = n + core_delay;
                if (n == 0 && check_err_clear) check_output("err_sticky_until_go", int'(err_timeout), 1);
                if (n == 1) begin
                    check_output("first_cycle_bit_cnt", int'(bit_cnt), 0);
                    check_output("first_cycle_busy", int'(busy), 1);
                    if (check_err_clear) check_output("err_cleared_by_go", int'(err_timeout), 0);
                end
                if (stall_left > 0) begin
                    check_output("stall_piso_shift_en", int'(piso_shift_en), 0);
                    check_output("stall_bit_cnt", int'(bit_cnt), 60);
                    stall_left--;
                end
                if (piso_shift_en) begin
                    shifts_out++;
                    if (stall && shifts_out == 60) stall_left = 5;
                end
                if (toggle_valid && n == 100) begin
                    check_output("invalid_cycle_bit_cnt", int'(bit_cnt), 50);
                    check_output("invalid_cycle_sipo", int'(sipo_shift_en), 0);
                end
                if (toggle_valid && n == 101) begin
                    check_output("valid_cycle_bit_cnt", int'(bit_cnt), 50);
                    check_output("valid_cycle_sipo", int'(sipo_shift_en), 1);
                end
                if (toggle_valid && n == 255) check_output("last_valid_no_ka", int'(core_rst_ka), 0);
                if (toggle_valid && n == 256) check_output("ka_after_last_valid", int'(core_rst_ka), 1);
                if (frame_done || (n > 0 && !busy)) begin
                    finished = 1'b1;
                end else if (n >= 1000) begin
                    total_cnt++;
                    $display("[TB] FAIL frame_budget: got no frame end after %0d cycles, expected end within 1000", n);
                    finished = 1'b1;
                end
            end
            n++;
        end
        scan_go        = 1'b0;
        scan_in_valid  = 1'b0;
        scan_out_ready = 1'b0;
        core_done      = 1'b0;
        if (abort_at >= 0) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    // Directed sequence of frames followed by end-of-run checks and the summary.
    initial begin
        reset          = 1'b1;
        scan_go        = 1'b0;
        scan_in_valid  = 1'b0;
        scan_out_ready = 1'b0;
        core_done      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_strobes",
                     int'({sipo_shift_en, core_rst_ka, core_start, core_en, piso_load,
                           piso_shift_en, busy, frame_done, err_timeout}), 0);
        check_output("reset_bit_cnt", int'(bit_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] nominal frame");
        push_exp(128, 2, 1, 1, 128, 1 + 128 + 2 + 1 + 10 + 1 + 128 + 1, 0);
        apply_stimulus(1'b0, 1'b0, 10, 1'b0, -1);

        $display("[TB] stalled shift-in");
        push_exp(128, 2, 1, 1, 128, 1 + 255 + 2 + 1 + 10 + 1 + 128 + 1, 0);
        apply_stimulus(1'b1, 1'b0, 10, 1'b0, -1);

        $display("[TB] shift-out backpressure");
        push_exp(128, 2, 1, 1, 128, 1 + 128 + 2 + 1 + 10 + 1 + 128 + 5 + 1, 0);
        apply_stimulus(1'b0, 1'b1, 10, 1'b0, -1);

        $display("[TB] core timeout");
        push_exp(128, 2, 1, 0, 0, 1 + 128 + 2 + 1 + 64, 1);
        apply_stimulus(1'b0, 1'b0, -1, 1'b0, -1);

        $display("[TB] error clear and ignored scan_go");
        check_err_clear = 1'b1;
        push_exp(128, 2, 1, 1, 128, 1 + 128 + 2 + 1 + 10 + 1 + 128 + 1, 0);
        apply_stimulus(1'b0, 1'b0, 10, 1'b1, -1);
        check_err_clear = 1'b0;

        $display("[TB] reset mid shift-in");
        apply_stimulus(1'b0, 1'b0, 10, 1'b0, 71);

        $display("[TB] fresh frame after reset");
        push_exp(128, 2, 1, 1, 128, 1 + 128 + 2 + 1 + 10 + 1 + 128 + 1, 0);
        apply_stimulus(1'b0, 1'b0, 10, 1'b0, -1);

        repeat (20) @(posedge clk);
        @(negedge clk);
        check_output("idle_busy_at_end", int'(busy), 0);
        check_output("pending_expectations", exp_q.size(), 0);
        check_output("total_frame_done_pulses", frames_done, 5);
        check_output("strobe_exclusivity_violations", excl_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
